connect_four_turn_controller: RTL
=================================

# connect_four_turn_controller

Turn sequencer and board owner for the Connect Four game. It holds the 6x7 board, accepts and validates human moves, and hands the registered board to the combinational `connectFourAI_defensive` datapath. After a settle window it commits the AI's chosen column, checks each commit for four-in-a-row or a full board, and reports the result. It sits between the user-input front end and the AI evaluator, and owns every write to `gameState`.

## Interface
Parameters:
- `AI_SETTLE`, default 2: cycles the board is held stable before the AI answer is sampled; legal range 1-15.
- `AI_FIRST`, default 0: 1 means the AI moves first after reset or a new game.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high; clears all state.
- `newGame`  in  1  synchronous clear with identical effect to `reset`; takes priority over all other inputs.
- `humanValid`  in  1  human move request.
- `humanCol`  in  3  requested column, 0-6.
- `humanReady`  out  1  high only in state HUMAN.
- `illegalMove`  out  1  one-cycle pulse when a request is rejected.
- `aiMove`  in  4  column chosen by the AI datapath.
- `aiScore`  in  5  `maxConnectOut` from the AI datapath; 30 means a winning move.
- `gameState`  out  84  registered board, fed to the AI and the display.
- `aiMoveValid`  out  1  one-cycle pulse when the AI piece is committed.
- `aiMoveCol`  out  3  column of the last AI commit; held between pulses.
- `gameOver`  out  1  high in state DONE.
- `winner`  out  2  00 = none or draw, 01 = AI, 10 = human; valid while `gameOver` is high.
- `turnCount`  out  6  pieces on the board, 0-42.

## Operation
Board encoding:
- Row r (0 = bottom) occupies `gameState[r*14 +: 14]`.
- Cell c of a row is bits `[2c+1:2c]`: bit 2c marks an AI piece, bit 2c+1 marks a human piece. Both set is never legal.
- Seven 3-bit height counters, `h[c]` in 0-6. A drop into column c writes row `h[c]`, then increments `h[c]` and `turnCount`.

States and transitions:
- HUMAN: waits for `humanValid`.
  - Accept when `humanCol` <= 6 and `h[humanCol]` < 6: write the human bit, go to HCHECK.
  - Otherwise pulse `illegalMove` next cycle and stay in HUMAN.
- HCHECK: evaluate the registered board for a human four-in-a-row (horizontal, vertical, both diagonals; all 69 windows).
  - Win: `winner` = 10, go to DONE.
  - Else if `turnCount` == 42: go to DONE with `winner` = 00.
  - Else: go to AI_WAIT.
- AI_WAIT: 4-bit counter loads `AI_SETTLE`-1 on entry and decrements each cycle; go to AI_PLACE when it reaches 0. The board is not written in this state.
- AI_PLACE: sample `aiMove`.
  - If `aiMove` > 6 or that column is full, substitute the lowest-index non-full column.
  - Write the AI bit, register `aiMoveCol`, and pulse `aiMoveValid`.
  - Record whether `aiScore` == 30 as a diagnostic flag only; it does not decide the game.
  - Go to ACHECK.
- ACHECK: same window check for AI pieces.
  - Win: `winner` = 01, go to DONE.
  - Else if the board is full: go to DONE with `winner` = 00.
  - Else: go to HUMAN.
- DONE: hold the board and outputs. Leave only on `reset` or `newGame`.

Reset and newGame behaviour:
- Clear board, heights, `turnCount`, `winner`, `aiMoveCol` and all pulses.
- Enter HUMAN if `AI_FIRST` = 0, otherwise AI_WAIT.
- Hence the reset value of `humanReady` is `!AI_FIRST`. Every other output resets to 0.

Boundary rules:
- `humanValid` outside HUMAN is ignored: no pulse and no write.
- `newGame` asserted in the same cycle as `humanValid` means the clear wins and the move is dropped.
- `reset` or `newGame` during AI_WAIT or AI_PLACE aborts the turn; no `aiMoveValid` pulse is produced.
- `turnCount` saturates at 42 and the height counters never exceed 6.

## Timing
Human move accepted at the cycle-T edge:
- T+1: board and `turnCount` updated; state HCHECK.
- T+2 to T+1+`AI_SETTLE`: AI_WAIT.
- T+2+`AI_SETTLE`: AI_PLACE.
- T+3+`AI_SETTLE`: AI bit visible on `gameState`, `aiMoveValid` high, state ACHECK.
- T+4+`AI_SETTLE`: `humanReady` high again.

Other timing:
- `illegalMove` is high exactly one cycle, at T+1.
- `gameOver` rises one cycle after the deciding CHECK state.
- All outputs are registered or decoded directly from state; there are no combinational paths from inputs to outputs.

## Test plan
- Reset with `AI_FIRST`=0, `AI_SETTLE`=2, human plays column 3 at T -> `gameState[7]`=1 at T+1; `aiMoveValid` at T+5 with `aiMoveCol`=3 (AI stacks on the threat tie); `humanReady` at T+6; `turnCount`=2.
- Fill column 0 to six pieces, then request column 0 and then column 7 -> an `illegalMove` pulse for each; board, `turnCount` and state unchanged.
- Human drops 4 in column 1 while the AI model is forced to column 6 -> at the fourth human move HCHECK gives `gameOver`=1 and `winner`=10, with no AI pulse; a further `humanValid` is ignored.
- AI model scripted to complete a horizontal row 0 in columns 3-6 -> `winner`=01; `gameOver` rises the cycle after ACHECK.
- Scripted 42-move sequence with no four-in-a-row -> `turnCount`=42, `gameOver`=1, `winner`=00.
- `newGame` in the second AI_WAIT cycle -> next cycle board = 0 and `turnCount`=0; no `aiMoveValid`; with `AI_FIRST`=1 the AI commits after `AI_SETTLE`+1 cycles.

Source files
------------

// File: rtl/connect_four_turn_controller.sv
// Connect Four turn sequencer and board owner.
// Validates human drops, commits AI drops, detects wins and draws.
module connect_four_turn_controller #(
    parameter int unsigned AI_SETTLE = 2,
    parameter bit          AI_FIRST  = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        newGame,
    input  logic        humanValid,
    input  logic [2:0]  humanCol,
    output logic        humanReady,
    output logic        illegalMove,
    input  logic [3:0]  aiMove,
    input  logic [4:0]  aiScore,
    output logic [83:0] gameState,
    output logic        aiMoveValid,
    output logic [2:0]  aiMoveCol,
    output logic        gameOver,
    output logic [1:0]  winner,
    output logic [5:0]  turnCount
);

    typedef enum logic [2:0] {
        S_HUMAN,
        S_HCHECK,
        S_AI_WAIT,
        S_AI_PLACE,
        S_ACHECK,
        S_DONE
    } state_e;

    localparam state_e     START     = AI_FIRST ? S_AI_WAIT : S_HUMAN;
    localparam logic [3:0] SETTLE_LD = 4'(AI_SETTLE - 1);
    localparam logic [5:0] CELLS     = 6'd42;

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [83:0]       board_q, board_d;
    logic [6:0][2:0]   h_q, h_d;
    logic [5:0]        turn_q, turn_d;
    logic [1:0]        winner_q, winner_d;
    logic [2:0]        aicol_q, aicol_d;
    logic              illegal_q, illegal_d;
    logic              aivalid_q, aivalid_d;
    logic              claim_unused_q, claim_unused_d;

    logic              clear;
    logic [6:0]        full;
    logic [7:0]        bad_col;
    logic [2:0]        hrow;
    logic [2:0]        lowest;
    logic [2:0]        acol;
    logic [2:0]        arow;
    logic              hum_ok;
    logic [6:0]        h_bit;
    logic [6:0]        a_bit;
    logic [5:0]        turn_inc;
    logic [5:0][6:0]   grid_a;
    logic [5:0][6:0]   grid_h;
    logic              win_a;
    logic              win_h;
    logic              board_full;

    // Scan all 69 four-cell windows of one player's occupancy grid.
    function automatic logic four_in_row(input logic [5:0][6:0] g);
        logic hit;
        hit = 1'b0;
        for (int r = 0; r < 6; r++)
            for (int c = 0; c < 4; c++)
                hit |= g[r][c] & g[r][c+1] & g[r][c+2] & g[r][c+3];
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 7; c++)
                hit |= g[r][c] & g[r+1][c] & g[r+2][c] & g[r+3][c];
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 4; c++)
                hit |= g[r][c] & g[r+1][c+1] & g[r+2][c+2] & g[r+3][c+3];
        for (int r = 0; r < 3; r++)
            for (int c = 3; c < 7; c++)
                hit |= g[r][c] & g[r+1][c-1] & g[r+2][c-2] & g[r+3][c-3];
        return hit;
    endfunction

    assign clear      = reset | newGame;
    assign bad_col    = {1'b1, full};
    assign hum_ok     = !bad_col[humanCol];
    assign h_bit      = 7'(hrow) * 7'd14 + {3'b000, humanCol, 1'b1};
    assign a_bit      = 7'(arow) * 7'd14 + {3'b000, acol, 1'b0};
    assign turn_inc   = (turn_q < CELLS) ? turn_q + 6'd1 : turn_q;
    assign board_full = (turn_q == CELLS);
    assign win_a      = four_in_row(grid_a);
    assign win_h      = four_in_row(grid_h);

    // Split the packed board into per-player occupancy grids.
    always_comb begin
        grid_a = '0;
        grid_h = '0;
        for (int r = 0; r < 6; r++) begin
            for (int c = 0; c < 7; c++) begin
                grid_a[r][c] = board_q[r*14 + 2*c];
                grid_h[r][c] = board_q[r*14 + 2*c + 1];
            end
        end
    end

    // Column fullness and the landing row of the requested human column.
    always_comb begin
        full = '0;
        hrow = '0;
        for (int c = 0; c < 7; c++) begin
            full[c] = (h_q[c] == 3'd6);
            if (humanCol == 3'(c)) hrow = h_q[c];
        end
    end

    // AI column with fallback to the lowest open column, plus its row.
    always_comb begin
        lowest = '0;
        arow   = '0;
        for (int c = 6; c >= 0; c--) begin
            if (!full[c]) lowest = 3'(c);
        end
        if (aiMove <= 4'd6 && !bad_col[aiMove[2:0]]) acol = aiMove[2:0];
        else acol = lowest;
        for (int c = 0; c < 7; c++) begin
            if (acol == 3'(c)) arow = h_q[c];
        end
    end

    // FSM state and settle counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= START;
            cnt_q   <= SETTLE_LD;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (clear) begin
            state_d = START;
            cnt_d   = SETTLE_LD;
        end else begin
            unique case (state_q)
                S_HUMAN: begin
                    if (humanValid && hum_ok) state_d = S_HCHECK;
                end
                S_HCHECK: begin
                    if (win_h || board_full) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_AI_WAIT;
                        cnt_d   = SETTLE_LD;
                    end
                end
                S_AI_WAIT: begin
                    if (cnt_q == 4'd0) state_d = S_AI_PLACE;
                    else cnt_d = cnt_q - 4'd1;
                end
                S_AI_PLACE: state_d = S_ACHECK;
                S_ACHECK: begin
                    if (win_a || board_full) state_d = S_DONE;
                    else state_d = S_HUMAN;
                end
                S_DONE: state_d = S_DONE;
                default: state_d = START;
            endcase
        end
    end

    // FSM outputs decoded straight from state.
    always_comb begin
        humanReady = (state_q == S_HUMAN);
        gameOver   = (state_q == S_DONE);
    end

    // Board, heights, counters and pulses: next values per state.
    always_comb begin
        board_d        = board_q;
        h_d            = h_q;
        turn_d         = turn_q;
        winner_d       = winner_q;
        aicol_d        = aicol_q;
        illegal_d      = 1'b0;
        aivalid_d      = 1'b0;
        claim_unused_d = claim_unused_q;
        if (clear) begin
            board_d        = '0;
            h_d            = '0;
            turn_d         = '0;
            winner_d       = '0;
            aicol_d        = '0;
            claim_unused_d = 1'b0;
        end else begin
            unique case (state_q)
                S_HUMAN: begin
                    if (humanValid && hum_ok) begin
                        board_d[h_bit] = 1'b1;
                        turn_d         = turn_inc;
                        for (int c = 0; c < 7; c++) begin
                            if (humanCol == 3'(c)) h_d[c] = h_q[c] + 3'd1;
                        end
                    end else if (humanValid) begin
                        illegal_d = 1'b1;
                    end
                end
                S_HCHECK: begin
                    if (win_h) winner_d = 2'b10;
                end
                S_AI_PLACE: begin
                    if (!(&full)) begin
                        board_d[a_bit] = 1'b1;
                        turn_d         = turn_inc;
                        for (int c = 0; c < 7; c++) begin
                            if (acol == 3'(c)) h_d[c] = h_q[c] + 3'd1;
                        end
                        aicol_d   = acol;
                        aivalid_d = 1'b1;
                    end
                    claim_unused_d = (aiScore == 5'd30);
                end
                S_ACHECK: begin
                    if (win_a) winner_d = 2'b01;
                end
                default: begin
                end
            endcase
        end
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            board_q        <= '0;
            h_q            <= '0;
            turn_q         <= '0;
            winner_q       <= '0;
            aicol_q        <= '0;
            illegal_q      <= 1'b0;
            aivalid_q      <= 1'b0;
            claim_unused_q <= 1'b0;
        end else begin
            board_q        <= board_d;
            h_q            <= h_d;
            turn_q         <= turn_d;
            winner_q       <= winner_d;
            aicol_q        <= aicol_d;
            illegal_q      <= illegal_d;
            aivalid_q      <= aivalid_d;
            claim_unused_q <= claim_unused_d;
        end
    end

    assign gameState   = board_q;
    assign illegalMove = illegal_q;
    assign aiMoveValid = aivalid_q;
    assign aiMoveCol   = aicol_q;
    assign winner      = winner_q;
    assign turnCount   = turn_q;

endmodule
